// File: rtl/peripheral_mult_gen.sv
// peripheral_mult_gen
// Memory-mapped multiplier peripheral for the femtoRV I/O bus. Operands A and B
// are WIDTH bits wide. A radix-2 shift-add engine produces a 2*WIDTH-bit product,
// either unsigned or signed. Signed products are formed as a sign-magnitude
// multiply with a final two's-complement fix-up.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   reset  - asynchronous active-low reset
//   d_in   - write data (operands use d_in[WIDTH-1:0])
//   cs     - peripheral select from the address decoder
//   addr   - word-aligned register offset
//   rd     - read strobe, qualified by cs
//   wr     - write strobe, qualified by cs
//   d_out  - read data; zero when the peripheral is not being read
//   irq    - level interrupt, done & irq_en
//
// Register map:
//   0x04 A   0x08 B   0x0C CTRL {irq_en, signed, start}
//   0x10 RESULT_LO   0x14 STATUS {busy, done(W1C)}   0x18 RESULT_HI
module peripheral_mult_gen #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  output logic        irq
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [4:0] ADDR_A      = 5'h04;
  localparam logic [4:0] ADDR_B      = 5'h08;
  localparam logic [4:0] ADDR_CTRL   = 5'h0C;
  localparam logic [4:0] ADDR_RES_LO = 5'h10;
  localparam logic [4:0] ADDR_STATUS = 5'h14;
  localparam logic [4:0] ADDR_RES_HI = 5'h18;

  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    ONE_P    = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    ONE_C    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic [WIDTH-1:0] a_r, b_r;
  logic             signed_r, irq_en_r;
  logic             busy_r, done_r;
  logic [PW-1:0]    result_r;
  logic [PW-1:0]    acc_r;
  logic [PW-1:0]    mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic             neg_r;
  logic [CW-1:0]    count_r;

  logic wr_a_s, wr_b_s, wr_ctrl_s, wr_status_s;
  logic start_s, w1c_s;
  logic [63:0] prod_ext_s;
  logic [31:0] rdata_s;
  logic        unused_din_s;

  // Absolute value of an operand when signed mode applies; the most negative
  // value maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    if (sgn && v[WIDTH-1]) begin
      magnitude = ~v + ONE_W;
    end else begin
      magnitude = v;
    end
  endfunction

  // Two's-complement negation of a full-width product.
  function automatic logic [PW-1:0] negate_prod(input logic [PW-1:0] v);
    negate_prod = ~v + ONE_P;
  endfunction

  assign wr_a_s      = cs & wr & (addr == ADDR_A);
  assign wr_b_s      = cs & wr & (addr == ADDR_B);
  assign wr_ctrl_s   = cs & wr & (addr == ADDR_CTRL);
  assign wr_status_s = cs & wr & (addr == ADDR_STATUS);

  // A start is only honoured while the engine is idle; otherwise it is dropped.
  assign start_s = wr_ctrl_s & d_in[0] & (state_r == S_IDLE);
  assign w1c_s   = wr_status_s & d_in[0];

  // Only the low operand bits and CTRL/STATUS bits of d_in carry meaning.
  assign unused_din_s = ^d_in;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN for WIDTH cycles, one FIX cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_s) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (count_r == LAST_CNT) begin
          state_nxt_s = S_FIX;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_FIX:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Software-visible configuration registers; writable even while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      signed_r <= 1'b0;
      irq_en_r <= 1'b0;
    end else begin
      if (wr_a_s) begin
        a_r <= d_in[WIDTH-1:0];
      end
      if (wr_b_s) begin
        b_r <= d_in[WIDTH-1:0];
      end
      if (wr_ctrl_s) begin
        signed_r <= d_in[1];
        irq_en_r <= d_in[2];
      end
    end
  end

  // Shift-add engine and the product register.
  // The signed bit comes straight from the start write, so a single CTRL
  // write can both select the mode and launch the operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r    <= {PW{1'b0}};
      mcand_r  <= {PW{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      neg_r    <= 1'b0;
      count_r  <= {CW{1'b0}};
      result_r <= {PW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            acc_r    <= {PW{1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, magnitude(a_r, d_in[1])};
            mplier_r <= magnitude(b_r, d_in[1]);
            neg_r    <= d_in[1] & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
            count_r  <= {CW{1'b0}};
          end
        end
        S_RUN: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          count_r  <= count_r + ONE_C;
        end
        S_FIX: begin
          result_r <= neg_r ? negate_prod(acc_r) : acc_r;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Busy/done status. Start takes priority over a same-cycle W1C of done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start_s) begin
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (state_r == S_FIX) begin
      busy_r <= 1'b0;
      done_r <= 1'b1;
    end else if (w1c_s) begin
      done_r <= 1'b0;
    end
  end

  // Zero-extend the product to 64 bits so RESULT_HI reads 0 for narrow widths.
  assign prod_ext_s = 64'(result_r);

  // Read-data mux; drives zero unless this peripheral is actively being read.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (cs && rd) begin
      case (addr)
        ADDR_A:      rdata_s = 32'(a_r);
        ADDR_B:      rdata_s = 32'(b_r);
        ADDR_CTRL:   rdata_s = {29'd0, irq_en_r, signed_r, 1'b0};
        ADDR_RES_LO: rdata_s = prod_ext_s[31:0];
        ADDR_STATUS: rdata_s = {30'd0, busy_r, done_r};
        ADDR_RES_HI: rdata_s = prod_ext_s[63:32];
        default:     rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign d_out = rdata_s;
  assign irq   = done_r & irq_en_r;

endmodule
